mem_arbiter: RTL and testbench

Parametrised memory-port arbiter that merges CH_CNT independent request/response channels onto the single memory port of the CPU top level. Typical clients are instruction fetch, data access and a debug/DMA client. Requests are granted round-robin and registered onto the memory port. Responses are returned in order to the originating channel via an internal tag FIFO that bounds the number of outstanding transactions.

---
 rtl/mem_arbiter_if.sv | 63 ++++++
 rtl/mem_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_if
//  Description : Bundle of the upstream multi-channel request/response bus
//                and the single downstream memory port of mem_arbiter.
//                'master' is the arbiter's view, 'slave' is the view of the
//                environment (clients plus memory).
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int CH_CNT     = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // Upstream request side, channels packed side by side
    logic [CH_CNT*ADDR_WIDTH-1:0]     up_req_addr;
    logic [CH_CNT-1:0]                up_req_we;
    logic [CH_CNT*DATA_WIDTH-1:0]     up_req_data;
    logic [CH_CNT*(DATA_WIDTH/8)-1:0] up_req_be;
    logic [CH_CNT-1:0]                up_req_valid;
    logic [CH_CNT-1:0]                up_req_ready;

    // Upstream response side; data is shared, valid is per channel
    logic [DATA_WIDTH-1:0]            up_resp_data;
    logic [CH_CNT-1:0]                up_resp_valid;
    logic [CH_CNT-1:0]                up_resp_ready;

    // Memory request port
    logic [ADDR_WIDTH-1:0]            mem_req_addr;
    logic                             mem_req_we;
    logic [DATA_WIDTH-1:0]            mem_req_data;
    logic [DATA_WIDTH/8-1:0]          mem_req_be;
    logic                             mem_req_valid;
    logic                             mem_req_ready;

    // Memory response port
    logic [DATA_WIDTH-1:0]            mem_resp_data;
    logic                             mem_resp_valid;
    logic                             mem_resp_ready;

    modport master (
        input  up_req_addr, up_req_we, up_req_data, up_req_be, up_req_valid,
        output up_req_ready,
        output up_resp_data, up_resp_valid,
        input  up_resp_ready,
        output mem_req_addr, mem_req_we, mem_req_data, mem_req_be, mem_req_valid,
        input  mem_req_ready,
        input  mem_resp_data, mem_resp_valid,
        output mem_resp_ready
    );

    modport slave (
        output up_req_addr, up_req_we, up_req_data, up_req_be, up_req_valid,
        input  up_req_ready,
        input  up_resp_data, up_resp_valid,
        output up_resp_ready,
        input  mem_req_addr, mem_req_we, mem_req_data, mem_req_be, mem_req_valid,
        output mem_req_ready,
        output mem_resp_data, mem_resp_valid,
        input  mem_resp_ready
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Round-robin arbiter merging CH_CNT request/response channels
//                onto one registered memory port. A tag FIFO remembers the
//                channel of every outstanding request so that in-order memory
//                responses can be routed back combinationally.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int CH_CNT      = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int OUTSTANDING = 4
) (
    input  logic          clk,
    input  logic          rst,    // synchronous, active low
    mem_arbiter_if.master bus
);

    localparam int c_TAG_W = (CH_CNT > 1) ? $clog2(CH_CNT) : 1;
    localparam int c_BE_W  = DATA_WIDTH / 8;
    localparam int c_PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int c_CNT_W = $clog2(OUTSTANDING + 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic                    r_or_valid;
    logic [ADDR_WIDTH-1:0]   r_or_addr;
    logic                    r_or_we;
    logic [DATA_WIDTH-1:0]   r_or_data;
    logic [c_BE_W-1:0]       r_or_be;

    logic [c_TAG_W-1:0]      r_last;
    logic [c_TAG_W-1:0]      r_tag_mem [OUTSTANDING];
    logic [c_PTR_W-1:0]      r_wr_ptr;
    logic [c_PTR_W-1:0]      r_rd_ptr;
    logic [c_CNT_W-1:0]      r_count;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic                    w_or_can_load;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic                    w_found;
    logic [c_TAG_W-1:0]      w_winner;
    logic                    w_grant;
    logic [ADDR_WIDTH-1:0]   w_sel_addr;
    logic                    w_sel_we;
    logic [DATA_WIDTH-1:0]   w_sel_data;
    logic [c_BE_W-1:0]       w_sel_be;
    logic [CH_CNT-1:0]       w_req_ready;

    logic [c_TAG_W-1:0]      w_head;
    logic [CH_CNT-1:0]       w_head_hit;
    logic                    w_head_ready;
    logic                    w_resp_ready;
    logic                    w_pop;

    // Next pointer value with wrap at the FIFO depth (depth need not be 2^n)
    function automatic logic [c_PTR_W-1:0] f_ptr_inc(input logic [c_PTR_W-1:0] p);
        if (p == c_PTR_W'(OUTSTANDING - 1)) begin
            return '0;
        end
        return p + c_PTR_W'(1);
    endfunction

    assign w_or_can_load = !r_or_valid || bus.mem_req_ready;
    assign w_fifo_full   = (r_count == c_CNT_W'(OUTSTANDING));
    assign w_fifo_empty  = (r_count == '0);

    // Round-robin search: first the channels above 'last', then wrap around
    // to the channels at or below it, so 'last' itself has lowest priority.
    always_comb begin
        w_found    = 1'b0;
        w_winner   = '0;
        w_sel_addr = '0;
        w_sel_we   = 1'b0;
        w_sel_data = '0;
        w_sel_be   = '0;
        for (int j = 0; j < CH_CNT; j++) begin
            if (!w_found && bus.up_req_valid[j] && (j > int'(r_last))) begin
                w_found    = 1'b1;
                w_winner   = c_TAG_W'(j);
                w_sel_addr = bus.up_req_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_we   = bus.up_req_we[j];
                w_sel_data = bus.up_req_data[j*DATA_WIDTH +: DATA_WIDTH];
                w_sel_be   = bus.up_req_be[j*c_BE_W +: c_BE_W];
            end
        end
        for (int j = 0; j < CH_CNT; j++) begin
            if (!w_found && bus.up_req_valid[j] && (j <= int'(r_last))) begin
                w_found    = 1'b1;
                w_winner   = c_TAG_W'(j);
                w_sel_addr = bus.up_req_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_we   = bus.up_req_we[j];
                w_sel_data = bus.up_req_data[j*DATA_WIDTH +: DATA_WIDTH];
                w_sel_be   = bus.up_req_be[j*c_BE_W +: c_BE_W];
            end
        end
    end

    // A full FIFO blocks the grant even if a response pops this cycle; the
    // reset term keeps the upstream ready low while reset is held.
    assign w_grant = rst && w_or_can_load && !w_fifo_full && w_found;

    // Decode the grant into a one-hot ready vector
    always_comb begin
        w_req_ready = '0;
        for (int j = 0; j < CH_CNT; j++) begin
            w_req_ready[j] = w_grant && (w_winner == c_TAG_W'(j));
        end
    end

    // Response routing follows the oldest outstanding tag
    assign w_head = r_tag_mem[r_rd_ptr];

    // One-hot decode of the head tag, used for both valid and ready routing
    always_comb begin
        w_head_hit = '0;
        for (int j = 0; j < CH_CNT; j++) begin
            w_head_hit[j] = (w_head == c_TAG_W'(j));
        end
    end

    assign w_head_ready = |(bus.up_resp_ready & w_head_hit);
    // With nothing outstanding a memory response is bogus and never accepted
    assign w_resp_ready = !w_fifo_empty && w_head_ready;
    assign w_pop        = bus.mem_resp_valid && w_resp_ready;

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.up_req_ready   = w_req_ready;
    assign bus.up_resp_data   = bus.mem_resp_data;
    assign bus.up_resp_valid  = (bus.mem_resp_valid && !w_fifo_empty) ? w_head_hit : '0;
    assign bus.mem_resp_ready = w_resp_ready;

    assign bus.mem_req_valid  = r_or_valid;
    assign bus.mem_req_addr   = r_or_addr;
    assign bus.mem_req_we     = r_or_we;
    assign bus.mem_req_data   = r_or_data;
    assign bus.mem_req_be     = r_or_be;

    // ------------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------------

    // Output register: load on grant, otherwise empty once memory accepts it
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_or_valid <= 1'b0;
            r_or_addr  <= '0;
            r_or_we    <= 1'b0;
            r_or_data  <= '0;
            r_or_be    <= '0;
        end else if (w_grant) begin
            r_or_valid <= 1'b1;
            r_or_addr  <= w_sel_addr;
            r_or_we    <= w_sel_we;
            r_or_data  <= w_sel_data;
            r_or_be    <= w_sel_be;
        end else if (bus.mem_req_ready) begin
            r_or_valid <= 1'b0;
        end
    end

    // Round-robin pointer; starts at the top channel so channel 0 goes first
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_last <= c_TAG_W'(CH_CNT - 1);
        end else if (w_grant) begin
            r_last <= w_winner;
        end
    end

    // Tag FIFO pointers and occupancy; simultaneous push and pop cancel out
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_grant) begin
                r_wr_ptr <= f_ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_ptr_inc(r_rd_ptr);
            end
            case ({w_grant, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Tag storage; contents are only meaningful between push and pop
    always_ff @(posedge clk) begin
        if (w_grant) begin
            r_tag_mem[r_wr_ptr] <= w_winner;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Directed self-checking bench for mem_arbiter with three
//                channels and four outstanding transactions.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int c_CH  = 3;
    localparam int c_AW  = 32;
    localparam int c_DW  = 32;
    localparam int c_OUT = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mem_arbiter_if #(.CH_CNT(c_CH), .ADDR_WIDTH(c_AW), .DATA_WIDTH(c_DW)) bus ();

    mem_arbiter #(
        .CH_CNT      (c_CH),
        .ADDR_WIDTH  (c_AW),
        .DATA_WIDTH  (c_DW),
        .OUTSTANDING (c_OUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Move to just after the next rising edge
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs follow freshly driven inputs
    task automatic settle();
        #1;
    endtask

    task automatic set_addr(input int ch, input logic [c_AW-1:0] a);
        bus.up_req_addr[ch*c_AW +: c_AW] = a;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;

        // ---------------- reset / idle ----------------
        rst                = 1'b0;
        bus.up_req_valid   = 3'b111;
        bus.up_req_we      = '0;
        bus.up_req_data    = '0;
        bus.up_req_be      = '1;
        for (int i = 0; i < c_CH; i++) set_addr(i, 32'h1000 + 32'(i * 16));
        bus.up_resp_ready  = 3'b111;
        bus.mem_req_ready  = 1'b1;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        next();
        next();
        settle();
        chk("rst_up_req_ready",   64'(bus.up_req_ready),   64'h0);
        chk("rst_mem_req_valid",  64'(bus.mem_req_valid),  64'h0);
        chk("rst_mem_resp_ready", 64'(bus.mem_resp_ready), 64'h0);
        chk("rst_up_resp_valid",  64'(bus.up_resp_valid),  64'h0);

        // ---------------- round robin, memory answers two cycles later ----
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            bus.mem_resp_valid = (k >= 2);
            bus.mem_resp_data  = 32'hA000 + 32'(k);
            settle();
            chk("rr_grant", 64'(bus.up_req_ready), 64'(3'b001 << (k % 3)));
            if (k >= 1) begin
                chk("rr_mem_valid", 64'(bus.mem_req_valid), 64'h1);
                chk("rr_mem_addr",  64'(bus.mem_req_addr), 64'(32'h1000 + 32'(((k - 1) % 3) * 16)));
            end
            if (k >= 2) begin
                chk("rr_resp_valid", 64'(bus.up_resp_valid), 64'(3'b001 << ((k - 2) % 3)));
                chk("rr_resp_data",  64'(bus.up_resp_data),  64'(32'hA000 + 32'(k)));
            end
            next();
        end

        // Drain the two remaining tags (channels 1 and 2)
        bus.up_req_valid   = 3'b000;
        bus.mem_resp_valid = 1'b1;
        settle();
        chk("drain_resp0", 64'(bus.up_resp_valid), 64'h2);
        next();
        settle();
        chk("drain_resp1", 64'(bus.up_resp_valid), 64'h4);
        next();

        // ---------------- spurious response with empty FIFO ----------------
        settle();
        chk("spur_mem_resp_ready", 64'(bus.mem_resp_ready), 64'h0);
        chk("spur_up_resp_valid",  64'(bus.up_resp_valid),  64'h0);
        next();
        chk("spur_count", 64'(dut.r_count), 64'h0);
        bus.mem_resp_valid = 1'b0;

        // ---------------- outstanding limit ----------------
        bus.up_req_valid = 3'b001;
        for (int d = 0; d < 4; d++) begin
            settle();
            chk("lim_grant", 64'(bus.up_req_ready), 64'h1);
            next();
        end
        settle();
        chk("lim_full_block0", 64'(bus.up_req_ready), 64'h0);
        next();
        settle();
        chk("lim_full_block1", 64'(bus.up_req_ready), 64'h0);
        chk("lim_or_drained",  64'(bus.mem_req_valid), 64'h0);
        bus.mem_resp_valid = 1'b1;
        settle();
        chk("lim_pop_resp_valid", 64'(bus.up_resp_valid),  64'h1);
        chk("lim_pop_resp_ready", 64'(bus.mem_resp_ready), 64'h1);
        chk("lim_pop_no_grant",   64'(bus.up_req_ready),   64'h0);
        next();
        bus.mem_resp_valid = 1'b0;
        settle();
        chk("lim_after_pop_grant", 64'(bus.up_req_ready), 64'h1);
        next();
        bus.up_req_valid   = 3'b000;
        bus.mem_resp_valid = 1'b1;
        for (int d = 0; d < 4; d++) begin
            settle();
            chk("lim_drain", 64'(bus.up_resp_valid), 64'h1);
            next();
        end
        bus.mem_resp_valid = 1'b0;

        // ---------------- memory request back-pressure ----------------
        bus.mem_req_ready = 1'b0;
        bus.up_req_valid  = 3'b110;
        settle();
        chk("bp_grant_ch1", 64'(bus.up_req_ready), 64'h2);
        next();
        set_addr(1, 32'h0000_BAD0);
        for (int e = 0; e < 5; e++) begin
            settle();
            chk("bp_no_grant",  64'(bus.up_req_ready),  64'h0);
            chk("bp_hold_valid", 64'(bus.mem_req_valid), 64'h1);
            chk("bp_hold_addr",  64'(bus.mem_req_addr),  64'h1010);
            next();
        end
        bus.mem_req_ready = 1'b1;
        settle();
        chk("bp_release_grant_ch2", 64'(bus.up_req_ready), 64'h4);
        chk("bp_release_addr",      64'(bus.mem_req_addr), 64'h1010);
        next();
        set_addr(1, 32'h1010);

        // ---------------- response head-of-line blocking ----------------
        bus.up_req_valid   = 3'b000;
        bus.mem_resp_valid = 1'b1;
        bus.up_resp_ready  = 3'b101;
        for (int e = 0; e < 2; e++) begin
            settle();
            chk("hol_mem_resp_ready", 64'(bus.mem_resp_ready), 64'h0);
            chk("hol_up_resp_valid",  64'(bus.up_resp_valid),  64'h2);
            next();
        end
        bus.up_resp_ready = 3'b111;
        settle();
        chk("hol_release_ready", 64'(bus.mem_resp_ready), 64'h1);
        chk("hol_release_valid", 64'(bus.up_resp_valid),  64'h2);
        next();
        settle();
        chk("hol_second_valid", 64'(bus.up_resp_valid), 64'h4);
        next();
        bus.mem_resp_valid = 1'b0;

        // ---------------- in-order routing ----------------
        set_addr(1, 32'h100);
        bus.up_req_we    = 3'b000;
        bus.up_req_valid = 3'b010;
        settle();
        chk("ord_grant_a", 64'(bus.up_req_ready), 64'h2);
        next();
        set_addr(0, 32'h200);
        bus.up_req_we    = 3'b001;
        bus.up_req_data[0 +: c_DW] = 32'h1111_2222;
        bus.up_req_valid = 3'b001;
        settle();
        chk("ord_grant_b", 64'(bus.up_req_ready), 64'h1);
        chk("ord_req_a_addr", 64'(bus.mem_req_addr), 64'h100);
        chk("ord_req_a_we",   64'(bus.mem_req_we),   64'h0);
        next();
        set_addr(1, 32'h300);
        bus.up_req_valid = 3'b010;
        settle();
        chk("ord_grant_c", 64'(bus.up_req_ready), 64'h2);
        chk("ord_req_b_addr", 64'(bus.mem_req_addr), 64'h200);
        chk("ord_req_b_we",   64'(bus.mem_req_we),   64'h1);
        chk("ord_req_b_data", 64'(bus.mem_req_data), 64'h1111_2222);
        next();
        bus.up_req_valid   = 3'b000;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 32'h0000_00D1;
        settle();
        chk("ord_req_c_addr", 64'(bus.mem_req_addr),  64'h300);
        chk("ord_resp1_valid", 64'(bus.up_resp_valid), 64'h2);
        chk("ord_resp1_data",  64'(bus.up_resp_data),  64'hD1);
        next();
        bus.mem_resp_data = 32'h0000_00D2;
        settle();
        chk("ord_resp2_valid", 64'(bus.up_resp_valid), 64'h1);
        chk("ord_resp2_data",  64'(bus.up_resp_data),  64'hD2);
        next();
        bus.mem_resp_data = 32'h0000_00D3;
        settle();
        chk("ord_resp3_valid", 64'(bus.up_resp_valid), 64'h2);
        chk("ord_resp3_data",  64'(bus.up_resp_data),  64'hD3);
        next();
        bus.mem_resp_valid = 1'b0;

        // ---------------- reset in the middle of a transaction ----------------
        bus.up_req_valid = 3'b001;
        settle();
        chk("mid_grant_ch0", 64'(bus.up_req_ready), 64'h1);
        next();
        rst              = 1'b0;
        bus.up_req_valid = 3'b111;
        settle();
        chk("mid_rst_no_grant", 64'(bus.up_req_ready), 64'h0);
        next();
        rst                = 1'b1;
        bus.up_req_valid   = 3'b000;
        bus.mem_resp_valid = 1'b1;
        settle();
        chk("mid_or_flushed",    64'(bus.mem_req_valid),  64'h0);
        chk("mid_late_resp_rdy", 64'(bus.mem_resp_ready), 64'h0);
        chk("mid_late_resp_vld", 64'(bus.up_resp_valid),  64'h0);
        next();
        bus.mem_resp_valid = 1'b0;
        bus.up_req_valid   = 3'b111;
        settle();
        chk("mid_ch0_first", 64'(bus.up_req_ready), 64'h1);
        next();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
